mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide external code/data memory between the multicycle MIPS core and a host loader/debug port.
- The core keeps zero-latency, same-cycle access whenever it is granted.
- The host gets a fixed 3-cycle request/acknowledge transaction.
- Provides cpu_stall so the core controller can hold its current state while the host owns memory.
- Sits between the core datapath (adr/writedata/memdata) and the memory instance.

Parameters:
- WIDTH, 8: address and data width in bits; matches the core datapath width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cpu_req  input  1  core memory access this cycle (memread|memwrite)
- cpu_we  input  1  core write strobe
- cpu_adr  input  WIDTH  core byte address
- cpu_wdata  input  WIDTH  core write data
- cpu_rdata  output  WIDTH  read data to core; combinational, mem_rdata pass-through
- cpu_stall  output  1  core must hold state and repeat its access next cycle
- host_req  input  1  host access request; level, held until host_ack
- host_we  input  1  host write strobe; stable while host_req=1
- host_adr  input  WIDTH  host byte address; stable while host_req=1
- host_wdata  input  WIDTH  host write data; stable while host_req=1
- host_lock  input  1  host takes absolute priority (bulk program load)
- host_ack  output  1  one-cycle completion pulse
- host_rdata  output  WIDTH  registered host read data; valid from host_ack onward
- mem_we  output  1  memory write enable; memory writes on posedge clk
- mem_adr  output  WIDTH  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_rdata  input  WIDTH  memory read data; asynchronous read

Behaviour:
- Reset:
  - Values: state=IDLE, prio=CPU, host_ack=0, host_rdata=0.
  - While reset=1: mem_we=0 and cpu_stall=0.
  - Reset mid-transaction abandons it: no write is issued and no ack is given.
- States: IDLE, HOST_XFER, HOST_ACK. prio is a 1-bit round-robin pointer (CPU/HOST).
- Grant rules:
  - cpu_gnt = cpu_req & ~reset & (state!=HOST_XFER) & ~host_win.
  - host_win (IDLE only) = host_req & (host_lock | ~cpu_req | prio==HOST).
  - cpu_stall = cpu_req & ~cpu_gnt.
- Memory mux:
  - In HOST_XFER the memory is driven from host_*.
  - Otherwise it is driven from cpu_* when cpu_gnt=1.
  - Otherwise mem_we=0 and mem_adr/mem_wdata=0.
  - mem_we = granted requester's we.
- IDLE:
  - host_win=1 -> HOST_XFER. The core is stalled this cycle if it requested.
  - cpu_gnt=1 -> stay IDLE; prio<=HOST if host_req, else unchanged.
- HOST_XFER:
  - Memory is owned by the host; the write commits at the end of the cycle.
  - host_rdata<=mem_rdata (for both reads and writes).
  - prio<=CPU, unless host_lock=1, in which case prio is unchanged.
  - Next state is HOST_ACK.
- HOST_ACK:
  - host_ack=1.
  - The memory is free to the core (cpu_gnt if cpu_req).
  - host_req is ignored this cycle even if still high.
  - Next state is IDLE.
- Host transaction latency: 3 cycles from host_req seen in IDLE to host_ack. Back-to-back host accesses occur at most every 3 cycles.
- Fairness:
  - Without host_lock, alternation is guaranteed: a stalled core waits at most 2 consecutive cycles (XFER, then granted in ACK).
  - With host_lock=1 the core can stall indefinitely.
- Dropping host_req before host_ack is a protocol violation; the transaction still completes.
- A core stall does not alter cpu_adr/cpu_wdata; the core re-presents the same access.

Test Plan:
- CPU only:
  - Stimulus: cpu_req=1, cpu_adr=0x10; memory holds 0xA5.
  - Required: cpu_rdata=0xA5 in the same cycle; cpu_stall=0; state stays IDLE.
- Host write then read, core idle:
  - Stimulus: host write 0x3C to 0x20, then host read 0x20.
  - Required: host_ack on cycle 3 of each transaction; host_rdata=0x3C at the second ack.
- Simultaneous requests, prio=CPU:
  - Stimulus: cpu_req=1 and host_req=1 in the same cycle.
  - Required cycle 1: CPU granted, prio->HOST.
  - Required cycle 2: host wins, cpu_stall=1.
  - Required cycle 3: HOST_XFER, cpu_stall=1.
  - Required cycle 4: host_ack=1, CPU granted, cpu_stall=0.
- host_lock load:
  - Stimulus: host_lock=1, four host writes 0x01..0x04 to 0x00..0x03, cpu_req held high.
  - Required: cpu_stall=1 except in the 4 ACK cycles; memory holds 0x04030201 afterwards.
- Reset mid-operation:
  - Stimulus: assert reset during HOST_XFER of a write of 0xFF to 0x08.
  - Required: mem[0x08] unchanged, host_ack never pulses, state=IDLE, host_rdata=0.
- Request held through ACK:
  - Stimulus: host_req stays high through HOST_ACK.
  - Required: no grant in the ACK cycle; a new transaction starts in the next IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: core access, host loader/debug access
// and the single byte-wide memory behind them.
interface mem_port_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             cpu_req;
   logic             cpu_we;
   logic [WIDTH-1:0] cpu_adr;
   logic [WIDTH-1:0] cpu_wdata;
   logic [WIDTH-1:0] cpu_rdata;
   logic             cpu_stall;

   logic             host_req;
   logic             host_we;
   logic [WIDTH-1:0] host_adr;
   logic [WIDTH-1:0] host_wdata;
   logic             host_lock;
   logic             host_ack;
   logic [WIDTH-1:0] host_rdata;

   logic             mem_we;
   logic [WIDTH-1:0] mem_adr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  host_req, host_we, host_adr, host_wdata, host_lock,
      output host_ack, host_rdata,
      output mem_we, mem_adr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output host_req, host_we, host_adr, host_wdata, host_lock,
      input  host_ack, host_rdata,
      input  mem_we, mem_adr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the external memory between the core (zero-latency)
// and the host port (fixed 3-cycle req/ack transaction).
module mem_port_arbiter #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      HOST_XFER,
      HOST_ACK
   } state_t;

   localparam logic PRIO_CPU  = 1'b0;
   localparam logic PRIO_HOST = 1'b1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_prio;
   logic             w_prio_nxt;
   logic [WIDTH-1:0] r_host_rdata;
   logic [WIDTH-1:0] w_host_rdata_nxt;
   logic             w_xfer;
   logic             w_host_win;
   logic             w_cpu_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_prio       <= PRIO_CPU;
         r_host_rdata <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_prio       <= w_prio_nxt;
         r_host_rdata <= w_host_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_prio_nxt       = r_prio;
      w_host_rdata_nxt = r_host_rdata;
      w_xfer           = (r_state == HOST_XFER);
      w_host_win       = (r_state == IDLE) & bus.host_req &
                         (bus.host_lock | ~bus.cpu_req |
                          (r_prio == PRIO_HOST));
      w_cpu_gnt        = bus.cpu_req & ~reset & ~w_xfer & ~w_host_win;
      unique case (r_state)
         IDLE: begin
            if (w_host_win)
               w_state_nxt = HOST_XFER;
            else if (w_cpu_gnt & bus.host_req)
               w_prio_nxt = PRIO_HOST;
         end
         HOST_XFER: begin
            // Captured for writes too: host sees the pre-write contents.
            w_host_rdata_nxt = bus.mem_rdata;
            if (!bus.host_lock)
               w_prio_nxt = PRIO_CPU;
            w_state_nxt = HOST_ACK;
         end
         HOST_ACK: w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // Reset gates the write strobe so an abandoned host write never lands.
   assign bus.mem_we    = ~reset & (w_xfer ? bus.host_we
                                           : (w_cpu_gnt & bus.cpu_we));
   assign bus.mem_adr   = w_xfer    ? bus.host_adr :
                          w_cpu_gnt ? bus.cpu_adr  : '0;
   assign bus.mem_wdata = w_xfer    ? bus.host_wdata :
                          w_cpu_gnt ? bus.cpu_wdata  : '0;

   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt & ~reset;
   assign bus.host_ack   = (r_state == HOST_ACK) & ~reset;
   assign bus.host_rdata = r_host_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       poke_en = 1'b0;
   logic [7:0] poke_adr = '0;
   logic [7:0] poke_dat = '0;

   mem_port_arbiter_if #(.WIDTH(8)) bus ();

   mem_port_arbiter #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_adr];

   always @(posedge clk) begin
      if (bus.mem_we)
         mem[bus.mem_adr] <= bus.mem_wdata;
      else if (poke_en)
         mem[poke_adr] <= poke_dat;
   end

   task automatic clear_in();
      bus.cpu_req    = 1'b0;
      bus.cpu_we     = 1'b0;
      bus.cpu_adr    = '0;
      bus.cpu_wdata  = '0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_adr   = '0;
      bus.host_wdata = '0;
      bus.host_lock  = 1'b0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      poke_adr = a;
      poke_dat = d;
      poke_en  = 1'b1;
      next_cyc();
      poke_en  = 1'b0;
   endtask

   task automatic host_txn(input logic we, input logic [7:0] a,
                           input logic [7:0] d, output int lat,
                           output logic [7:0] rd);
      bus.host_req   = 1'b1;
      bus.host_we    = we;
      bus.host_adr   = a;
      bus.host_wdata = d;
      lat = -1;
      rd  = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.host_ack) begin
            lat = c;
            rd  = bus.host_rdata;
            next_cyc();
            break;
         end
         next_cyc();
      end
      bus.host_req = 1'b0;
      bus.host_we  = 1'b0;
   endtask

   task automatic test_reset();
      clear_in();
      reset = 1'b1;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b1;
      bus.host_lock = 1'b1;
      next_cyc();
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall got=%b exp=0", bus.cpu_stall);
      end
      checks++;
      if (bus.mem_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we);
      end
      checks++;
      if (bus.host_ack !== 1'b0) begin
         failures++;
         $display("FAIL reset_ack got=%b exp=0", bus.host_ack);
      end
      checks++;
      if (bus.host_rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_rdata got=%h exp=00", bus.host_rdata);
      end
      next_cyc();
      clear_in();
      reset = 1'b0;
      next_cyc();
   endtask

   task automatic test_cpu_only();
      poke(8'h10, 8'hA5);
      bus.cpu_req = 1'b1;
      bus.cpu_adr = 8'h10;
      @(negedge clk);
      checks++;
      if (bus.cpu_rdata !== 8'hA5) begin
         failures++;
         $display("FAIL cpu_only_rdata got=%h exp=a5", bus.cpu_rdata);
      end
      checks++;
      if (bus.cpu_stall !== 1'b0) begin
         failures++;
         $display("FAIL cpu_only_stall got=%b exp=0", bus.cpu_stall);
      end
      next_cyc();
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b0 || bus.host_ack !== 1'b0) begin
         failures++;
         $display("FAIL cpu_only_idle stall=%b ack=%b exp=0/0",
                  bus.cpu_stall, bus.host_ack);
      end
      next_cyc();
      bus.cpu_we    = 1'b1;
      bus.cpu_adr   = 8'h11;
      bus.cpu_wdata = 8'h5A;
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b1) begin
         failures++;
         $display("FAIL cpu_only_we got=%b exp=1", bus.mem_we);
      end
      next_cyc();
      clear_in();
      checks++;
      if (mem[8'h11] !== 8'h5A) begin
         failures++;
         $display("FAIL cpu_only_write got=%h exp=5a", mem[8'h11]);
      end
   endtask

   task automatic test_host_wr_rd();
      int         lat;
      logic [7:0] rd;
      clear_in();
      host_txn(1'b1, 8'h20, 8'h3C, lat, rd);
      checks++;
      if (lat !== 3) begin
         failures++;
         $display("FAIL host_wr_latency got=%0d exp=3", lat);
      end
      checks++;
      if (mem[8'h20] !== 8'h3C) begin
         failures++;
         $display("FAIL host_wr_mem got=%h exp=3c", mem[8'h20]);
      end
      host_txn(1'b0, 8'h20, 8'h00, lat, rd);
      checks++;
      if (lat !== 3) begin
         failures++;
         $display("FAIL host_rd_latency got=%0d exp=3", lat);
      end
      checks++;
      if (rd !== 8'h3C) begin
         failures++;
         $display("FAIL host_rd_data got=%h exp=3c", rd);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_stall;
      logic [3:0] exp_ack;
      logic [7:0] exp_adr [4];
      exp_stall  = 4'b0110;
      exp_ack    = 4'b1000;
      exp_adr[0] = 8'h10;
      exp_adr[1] = 8'h00;
      exp_adr[2] = 8'h20;
      exp_adr[3] = 8'h10;
      clear_in();
      bus.cpu_req  = 1'b1;
      bus.cpu_adr  = 8'h10;
      bus.host_req = 1'b1;
      bus.host_adr = 8'h20;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (bus.cpu_stall !== exp_stall[c] ||
             bus.host_ack !== exp_ack[c] ||
             bus.mem_adr !== exp_adr[c]) begin
            failures++;
            $display("FAIL simul_c%0d stall=%b ack=%b adr=%h exp=%b/%b/%h",
                     c + 1, bus.cpu_stall, bus.host_ack, bus.mem_adr,
                     exp_stall[c], exp_ack[c], exp_adr[c]);
         end
         next_cyc();
      end
      bus.host_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b0 || bus.host_ack !== 1'b0) begin
         failures++;
         $display("FAIL simul_after stall=%b ack=%b exp=0/0",
                  bus.cpu_stall, bus.host_ack);
      end
      next_cyc();
      clear_in();
   endtask

   task automatic test_lock_load();
      int n_free;
      int n_stall;
      bit done;
      logic [31:0] word;
      n_free  = 0;
      n_stall = 0;
      clear_in();
      bus.cpu_req   = 1'b1;
      bus.cpu_adr   = 8'h40;
      bus.host_lock = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.host_req   = 1'b1;
         bus.host_we    = 1'b1;
         bus.host_adr   = 8'(k);
         bus.host_wdata = 8'(k + 1);
         done = 1'b0;
         for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (bus.cpu_stall !== !bus.host_ack) begin
               failures++;
               $display("FAIL lock_stall k=%0d c=%0d stall=%b ack=%b",
                        k, c, bus.cpu_stall, bus.host_ack);
            end
            if (bus.cpu_stall === 1'b1) n_stall++;
            else n_free++;
            done = bus.host_ack;
            next_cyc();
         end
         bus.host_req = 1'b0;
      end
      clear_in();
      checks++;
      if (n_free !== 4 || n_stall !== 8) begin
         failures++;
         $display("FAIL lock_counts free=%0d stall=%0d exp=4/8",
                  n_free, n_stall);
      end
      word = {mem[3], mem[2], mem[1], mem[0]};
      checks++;
      if (word !== 32'h04030201) begin
         failures++;
         $display("FAIL lock_mem got=%h exp=04030201", word);
      end
      next_cyc();
   endtask

   task automatic test_reset_mid();
      clear_in();
      poke(8'h08, 8'h11);
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_adr   = 8'h08;
      bus.host_wdata = 8'hFF;
      next_cyc();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_we got=%b exp=0", bus.mem_we);
      end
      next_cyc();
      reset = 1'b0;
      clear_in();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.host_ack !== 1'b0 || bus.host_rdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_after c=%0d ack=%b rdata=%h exp=0/00",
                     c, bus.host_ack, bus.host_rdata);
         end
         next_cyc();
      end
      checks++;
      if (mem[8'h08] !== 8'h11) begin
         failures++;
         $display("FAIL rst_mid_mem got=%h exp=11", mem[8'h08]);
      end
      bus.cpu_req = 1'b1;
      bus.cpu_adr = 8'h08;
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 8'h11) begin
         failures++;
         $display("FAIL rst_mid_idle stall=%b rdata=%h exp=0/11",
                  bus.cpu_stall, bus.cpu_rdata);
      end
      next_cyc();
      clear_in();
   endtask

   task automatic test_req_held();
      clear_in();
      bus.host_req = 1'b1;
      bus.host_adr = 8'h20;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (bus.host_ack !== ((c == 3) || (c == 6))) begin
            failures++;
            $display("FAIL held_ack c=%0d got=%b", c, bus.host_ack);
         end
         if (c == 3) begin
            checks++;
            if (bus.mem_adr !== 8'h00 || bus.mem_we !== 1'b0) begin
               failures++;
               $display("FAIL held_ack_grant adr=%h we=%b exp=00/0",
                        bus.mem_adr, bus.mem_we);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.mem_adr !== 8'h20) begin
               failures++;
               $display("FAIL held_second_xfer adr=%h exp=20", bus.mem_adr);
            end
         end
         next_cyc();
      end
      clear_in();
      next_cyc();
   endtask

   task automatic test_random();
      int         phase;
      bit         turn_host;
      bit         h_pend;
      bit         c_hold;
      bit         win;
      bit         served;
      bit         e_stall;
      bit         e_ack;
      logic [7:0] e_hrd;
      phase     = 0;
      turn_host = 1'b0;
      h_pend    = 1'b0;
      c_hold    = 1'b0;
      e_hrd     = 8'h00;
      clear_in();
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!h_pend && cyc < 390 && ($urandom % 3) == 0) begin
            bus.host_req   = 1'b1;
            bus.host_we    = 1'($urandom % 2);
            bus.host_adr   = 8'(8'h80 + ($urandom % 16));
            bus.host_wdata = 8'($urandom);
            bus.host_lock  = (($urandom % 5) == 0);
            h_pend = 1'b1;
         end
         if (!c_hold) begin
            bus.cpu_req   = (cyc < 395) ? 1'($urandom % 2) : 1'b0;
            bus.cpu_we    = 1'($urandom % 2);
            bus.cpu_adr   = 8'(8'h80 + ($urandom % 16));
            bus.cpu_wdata = 8'($urandom);
         end
         e_ack   = (phase == 2);
         win     = (phase == 0) && bus.host_req &&
                   (bus.host_lock || !bus.cpu_req || turn_host);
         served  = bus.cpu_req && (phase != 1) && !win;
         e_stall = bus.cpu_req && !served;
         @(negedge clk);
         checks++;
         if (bus.cpu_stall !== e_stall || bus.host_ack !== e_ack) begin
            failures++;
            $display("FAIL rand_ctl cyc=%0d stall=%b ack=%b exp=%b/%b",
                     cyc, bus.cpu_stall, bus.host_ack, e_stall, e_ack);
         end
         if (served && !bus.cpu_we) begin
            checks++;
            if (bus.cpu_rdata !== ref_mem[bus.cpu_adr]) begin
               failures++;
               $display("FAIL rand_cpu_rd cyc=%0d got=%h exp=%h", cyc,
                        bus.cpu_rdata, ref_mem[bus.cpu_adr]);
            end
         end
         if (e_ack) begin
            checks++;
            if (bus.host_rdata !== e_hrd) begin
               failures++;
               $display("FAIL rand_host_rd cyc=%0d got=%h exp=%h", cyc,
                        bus.host_rdata, e_hrd);
            end
         end
         if (phase == 1) begin
            e_hrd = ref_mem[bus.host_adr];
            if (bus.host_we) ref_mem[bus.host_adr] = bus.host_wdata;
            if (!bus.host_lock) turn_host = 1'b0;
            phase = 2;
         end else if (phase == 2) begin
            phase = 0;
         end else if (win) begin
            phase = 1;
         end else if (served && bus.host_req) begin
            turn_host = 1'b1;
         end
         if (served && bus.cpu_we) ref_mem[bus.cpu_adr] = bus.cpu_wdata;
         c_hold = e_stall;
         next_cyc();
         if (e_ack) begin
            bus.host_req  = 1'b0;
            bus.host_lock = 1'b0;
            h_pend = 1'b0;
         end
      end
      clear_in();
      for (int i = 8'h80; i < 8'h90; i++) begin
         checks++;
         if (mem[i] !== ref_mem[i]) begin
            failures++;
            $display("FAIL rand_mem adr=%h got=%h exp=%h", i[7:0],
                     mem[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      clear_in();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_cpu_only();
      test_host_wr_rd();
      test_simultaneous();
      test_lock_load();
      test_reset_mid();
      test_req_held();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
